// File: rtl/usart_cmd_parser.sv
// Frame decoder behind the UART receiver: 55 AA CMD LEN PAYLOAD[LEN] CHK -> decoded command / error pulses.
// Latency: cmd_valid / err_valid rise one clk after the strobe of the deciding byte (timeout: one clk after expiry).
// Backpressure: none; the receiver cannot be stalled, so pulses are single-cycle and cmd_* hold until the next good frame.
module usart_cmd_parser #(
    parameter int          MAX_LEN        = 8,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  INT_CMD        = 8'h01,
    parameter logic [15:0] INT_TIME_RST   = 16'd1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_int,
    input  logic [7:0]           rx_data,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_code,
    output logic [4:0]           cmd_len,
    output logic [MAX_LEN*8-1:0] cmd_payload,
    output logic [15:0]          int_time,
    output logic                 err_valid,
    output logic [1:0]           err_code
);

    localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    // Shadow is at least two bytes wide so the int_time load always has bytes 0 and 1 to read.
    localparam int              SW         = (MAX_LEN < 2) ? 16 : MAX_LEN * 8;
    localparam logic [7:0]      MAX_LEN_B  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_H0,
        S_H1,
        S_CMD,
        S_LEN,
        S_DATA,
        S_CHK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_int_d;
    logic            byte_stb;
    logic [7:0]      cmd_r;
    logic [4:0]      len_r;
    logic [7:0]      sum;
    logic [4:0]      idx;
    logic [SW-1:0]   shadow;
    logic [TW-1:0]   timer;

    logic            ld_cmd;
    logic            ld_len;
    logic            st_data;
    logic            frame_ok;
    logic            frame_bad;
    logic            len_err;
    logic            timeout_hit;

    // A byte is complete on the falling edge of the receiver busy level.
    assign byte_stb = rx_int_d & ~rx_int;

    // Delay rx_int by one clock for edge detection; resets low so a busy level at reset release is not a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_int_d <= 1'b0;
        end else begin
            rx_int_d <= rx_int;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_H0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-byte control decode; a byte strobe always wins over the timeout.
    always_comb begin
        state_nxt   = state;
        ld_cmd      = 1'b0;
        ld_len      = 1'b0;
        st_data     = 1'b0;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;
        len_err     = 1'b0;
        timeout_hit = 1'b0;
        if (byte_stb) begin
            case (state)
                S_H0: begin
                    if (rx_data == 8'h55) state_nxt = S_H1;
                end
                S_H1: begin
                    if (rx_data == 8'hAA)      state_nxt = S_CMD;
                    else if (rx_data == 8'h55) state_nxt = S_H1;
                    else                       state_nxt = S_H0;
                end
                S_CMD: begin
                    ld_cmd    = 1'b1;
                    state_nxt = S_LEN;
                end
                S_LEN: begin
                    if (rx_data > MAX_LEN_B) begin
                        len_err   = 1'b1;
                        state_nxt = S_H0;
                    end else begin
                        ld_len    = 1'b1;
                        state_nxt = (rx_data == 8'h00) ? S_CHK : S_DATA;
                    end
                end
                S_DATA: begin
                    st_data = 1'b1;
                    if (idx == len_r - 5'd1) state_nxt = S_CHK;
                end
                S_CHK: begin
                    if (rx_data == sum) frame_ok  = 1'b1;
                    else                frame_bad = 1'b1;
                    state_nxt = S_H0;
                end
                default: state_nxt = S_H0;
            endcase
        end else if (state != S_H0 && timer == TIMER_LAST) begin
            timeout_hit = 1'b1;
            state_nxt   = S_H0;
        end
    end

    // Inter-byte timer: idle in S_H0, restarted by every byte and by its own expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (byte_stb || state == S_H0 || timeout_hit) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Frame assembly: command/length latches, running checksum and payload shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r  <= '0;
            len_r  <= '0;
            sum    <= '0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            if (ld_cmd) begin
                cmd_r <= rx_data;
                sum   <= rx_data;
            end
            // Shadow is cleared for LEN=0 as well so an empty frame reports an all-zero payload.
            if (ld_len) begin
                len_r  <= rx_data[4:0];
                sum    <= sum + rx_data;
                idx    <= '0;
                shadow <= '0;
            end
            if (st_data) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (idx == 5'(i)) shadow[i*8 +: 8] <= rx_data;
                end
                sum <= sum + rx_data;
                idx <= idx + 5'd1;
            end
        end
    end

    // Registered outputs: publish good frames, load int_time, report discards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid   <= 1'b0;
            cmd_code    <= '0;
            cmd_len     <= '0;
            cmd_payload <= '0;
            int_time    <= INT_TIME_RST;
            err_valid   <= 1'b0;
            err_code    <= '0;
        end else begin
            cmd_valid <= frame_ok;
            err_valid <= len_err | frame_bad | timeout_hit;
            if (frame_ok) begin
                cmd_code    <= cmd_r;
                cmd_len     <= len_r;
                cmd_payload <= shadow[MAX_LEN*8-1:0];
                // Integration time arrives big-endian: first payload byte is the high byte.
                if (cmd_r == INT_CMD && len_r == 5'd2) begin
                    int_time <= {shadow[7:0], shadow[15:8]};
                end
            end
            if (len_err)          err_code <= 2'd2;
            else if (frame_bad)   err_code <= 2'd1;
            else if (timeout_hit) err_code <= 2'd3;
        end
    end

endmodule

// File: tb/tb_usart_cmd_parser.sv
// Directed bench for usart_cmd_parser: framed byte sequences with hand-computed results.
// Latency: outputs sampled on the falling clock edge right after the deciding byte's strobe edge.
// Backpressure: none; bytes are paced by the bench through rx_int.
module tb_usart_cmd_parser;

    localparam int MAX_LEN = 8;
    localparam int TO      = 200;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 rx_int;
    logic [7:0]           rx_data;
    logic                 cmd_valid;
    logic [7:0]           cmd_code;
    logic [4:0]           cmd_len;
    logic [MAX_LEN*8-1:0] cmd_payload;
    logic [15:0]          int_time;
    logic                 err_valid;
    logic [1:0]           err_code;

    int checks  = 0;
    int errors  = 0;
    int n_cmd   = 0;
    int n_err   = 0;
    int n_both  = 0;
    int exp_cmd = 0;
    int exp_err = 0;
    int wait_cnt;

    logic [7:0] q[$];

    usart_cmd_parser #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TO),
        .INT_CMD        (8'h01),
        .INT_TIME_RST   (16'd1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_int      (rx_int),
        .rx_data     (rx_data),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .int_time    (int_time),
        .err_valid   (err_valid),
        .err_code    (err_code)
    );

    always #10 clk = ~clk;

    // Pulse monitor: counts every cmd/err pulse and any cycle with both high.
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) n_cmd++;
        if (err_valid === 1'b1) n_err++;
        if (cmd_valid === 1'b1 && err_valid === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_int = 1'b1;
        repeat (2) @(negedge clk);
        rx_data = b;
        rx_int  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_q();
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic expect_cmd(input string tag, input logic [7:0] code, input logic [4:0] len,
                              input logic [63:0] pay, input logic [15:0] itime);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd1);
        chk({tag, "_no_err"}, 64'(err_valid), 64'd0);
        chk({tag, "_code"}, 64'(cmd_code), 64'(code));
        chk({tag, "_len"}, 64'(cmd_len), 64'(len));
        chk({tag, "_payload"}, 64'(cmd_payload), pay);
        chk({tag, "_int_time"}, 64'(int_time), 64'(itime));
        exp_cmd++;
        @(negedge clk);
        chk({tag, "_pulse_end"}, 64'(cmd_valid), 64'd0);
    endtask

    task automatic expect_err(input string tag, input logic [1:0] code);
        chk({tag, "_err_valid"}, 64'(err_valid), 64'd1);
        chk({tag, "_no_cmd"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_err_code"}, 64'(err_code), 64'(code));
        exp_err++;
        @(negedge clk);
        chk({tag, "_pulse_end"}, 64'(err_valid), 64'd0);
    endtask

    task automatic check_counts(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_n_cmd"}, 64'(n_cmd), 64'(exp_cmd));
        chk({tag, "_n_err"}, 64'(n_err), 64'(exp_err));
        chk({tag, "_n_both"}, 64'(n_both), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_err_valid"}, 64'(err_valid), 64'd0);
        chk({tag, "_cmd_code"}, 64'(cmd_code), 64'd0);
        chk({tag, "_cmd_len"}, 64'(cmd_len), 64'd0);
        chk({tag, "_payload"}, 64'(cmd_payload), 64'd0);
        chk({tag, "_int_time"}, 64'(int_time), 64'd1000);
        chk({tag, "_err_code"}, 64'(err_code), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_int  = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Bad checksum: EF instead of EE.
        q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'hE8, 8'hEF};
        send_q();
        expect_err("bad_chk", 2'd1);
        chk("bad_chk_int_time", 64'(int_time), 64'd1000);
        chk("bad_chk_code_held", 64'(cmd_code), 64'd0);
        check_counts("after_bad_chk");

        // Integration time load, big-endian.
        q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'hE8, 8'hEE};
        send_q();
        expect_cmd("int_load", 8'h01, 5'd2, 64'h0000_0000_0000_E803, 16'h03E8);
        chk("err_code_held", 64'(err_code), 64'd1);
        check_counts("after_int_load");

        // Zero-length frame.
        q = '{8'h55, 8'hAA, 8'h10, 8'h00, 8'h10};
        send_q();
        expect_cmd("len0", 8'h10, 5'd0, 64'h0, 16'h03E8);

        // INT_CMD with LEN=3 does not touch int_time.
        q = '{8'h55, 8'hAA, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
        send_q();
        expect_cmd("len3", 8'h01, 5'd3, 64'h0000_0000_0033_2211, 16'h03E8);
        check_counts("after_len3");

        // Length over MAX_LEN: error right after LEN, trailing bytes ignored.
        q = '{8'h55, 8'hAA, 8'h05, 8'h09};
        send_q();
        expect_err("len_err", 2'd2);
        q = '{8'h01, 8'h02, 8'h6A, 8'h00};
        send_q();
        chk("len_err_code_held", 64'(cmd_code), 64'h01);
        chk("len_err_len_held", 64'(cmd_len), 64'd3);
        check_counts("after_len_err");

        // Resync on repeated 0x55.
        q = '{8'h00, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h02, 8'h00, 8'h64, 8'h67};
        send_q();
        expect_cmd("resync", 8'h01, 5'd2, 64'h0000_0000_0000_6400, 16'h0064);

        // Timeout after CMD byte: expires exactly TO cycles after the last strobe.
        q = '{8'h55, 8'hAA, 8'h01};
        send_q();
        wait_cnt = 0;
        while (wait_cnt < 2 * TO && err_valid !== 1'b1) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("timeout_cycles", 64'(wait_cnt), 64'(TO));
        chk("timeout_code", 64'(err_code), 64'd3);
        chk("timeout_no_cmd", 64'(cmd_valid), 64'd0);
        exp_err++;
        q = '{8'h55, 8'hAA, 8'h10, 8'h00, 8'h10};
        send_q();
        expect_cmd("after_timeout", 8'h10, 5'd0, 64'h0, 16'h0064);
        check_counts("after_timeout");

        // Reset between LEN and payload, then remnants and a fresh frame.
        q = '{8'h55, 8'hAA, 8'h01, 8'h02};
        send_q();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        q = '{8'h03, 8'hE8, 8'hEE};
        send_q();
        check_counts("after_remnant");
        q = '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h07, 8'h0A};
        send_q();
        expect_cmd("post_reset", 8'h02, 5'd1, 64'h07, 16'd1000);
        check_counts("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
